easyaxi_rd_arb: RTL and testbench

Two-master AXI read-channel arbiter that shares one EASYAXI read slave between two requesters. It picks one master's AR request per handshake with round-robin arbitration and holds that grant until the slave accepts. It records the winner's index in an in-order grant FIFO and steers each R beat back to the owning master. R beats are routed by FIFO order, not by ID. The block sits between the master-side AXI ports and the slave `axi_slv_*` read ports.

---
 rtl/easyaxi_rd_arb.sv | 147 ++++++++++++++
 tb/tb_easyaxi_rd_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/easyaxi_rd_arb.sv
// Two-master read-channel arbiter in front of one EASYAXI read slave.
// Round-robin AR grant with stall lock; R beats steered by an in-order grant FIFO.
module easyaxi_rd_arb #(
  parameter int OST_DEPTH   = 8,
  parameter int AXI_ID_W    = 4,
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_LEN_W   = 8,
  parameter int AXI_SIZE_W  = 3,
  parameter int AXI_BURST_W = 2,
  parameter int AXI_DATA_W  = 32,
  parameter int AXI_RESP_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   axi_mst0_arvalid,
  output logic                   axi_mst0_arready,
  input  logic [AXI_ID_W-1:0]    axi_mst0_arid,
  input  logic [AXI_ADDR_W-1:0]  axi_mst0_araddr,
  input  logic [AXI_LEN_W-1:0]   axi_mst0_arlen,
  input  logic [AXI_SIZE_W-1:0]  axi_mst0_arsize,
  input  logic [AXI_BURST_W-1:0] axi_mst0_arburst,
  output logic                   axi_mst0_rvalid,
  input  logic                   axi_mst0_rready,
  output logic [AXI_ID_W-1:0]    axi_mst0_rid,
  output logic [AXI_DATA_W-1:0]  axi_mst0_rdata,
  output logic [AXI_RESP_W-1:0]  axi_mst0_rresp,
  output logic                   axi_mst0_rlast,
  input  logic                   axi_mst1_arvalid,
  output logic                   axi_mst1_arready,
  input  logic [AXI_ID_W-1:0]    axi_mst1_arid,
  input  logic [AXI_ADDR_W-1:0]  axi_mst1_araddr,
  input  logic [AXI_LEN_W-1:0]   axi_mst1_arlen,
  input  logic [AXI_SIZE_W-1:0]  axi_mst1_arsize,
  input  logic [AXI_BURST_W-1:0] axi_mst1_arburst,
  output logic                   axi_mst1_rvalid,
  input  logic                   axi_mst1_rready,
  output logic [AXI_ID_W-1:0]    axi_mst1_rid,
  output logic [AXI_DATA_W-1:0]  axi_mst1_rdata,
  output logic [AXI_RESP_W-1:0]  axi_mst1_rresp,
  output logic                   axi_mst1_rlast,
  output logic                   axi_slv_arvalid,
  input  logic                   axi_slv_arready,
  output logic [AXI_ID_W-1:0]    axi_slv_arid,
  output logic [AXI_ADDR_W-1:0]  axi_slv_araddr,
  output logic [AXI_LEN_W-1:0]   axi_slv_arlen,
  output logic [AXI_SIZE_W-1:0]  axi_slv_arsize,
  output logic [AXI_BURST_W-1:0] axi_slv_arburst,
  input  logic                   axi_slv_rvalid,
  output logic                   axi_slv_rready,
  input  logic [AXI_ID_W-1:0]    axi_slv_rid,
  input  logic [AXI_DATA_W-1:0]  axi_slv_rdata,
  input  logic [AXI_RESP_W-1:0]  axi_slv_rresp,
  input  logic                   axi_slv_rlast
);

  localparam int PTR_W = $clog2(OST_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(OST_DEPTH);

  logic                 rr_ptr_r;
  logic                 lock_r;
  logic                 lock_idx_r;
  logic [OST_DEPTH-1:0] fifo_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W:0]       cnt_r;

  logic full, empty, gnt_vld, gnt_idx, head, ar_hs, push, pop;

  assign full  = (cnt_r == CNT_FULL);
  assign empty = (cnt_r == '0);
  assign head  = fifo_r[rd_ptr_r];

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (lock_r) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx_r;
    end else if (enable && !full) begin
      if (axi_mst0_arvalid && axi_mst1_arvalid) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_ptr_r;
      end else if (axi_mst0_arvalid || axi_mst1_arvalid) begin
        gnt_vld = 1'b1;
        gnt_idx = axi_mst1_arvalid;
      end
    end
  end

  // AR path; everything is held at 0 while rst is high
  assign axi_slv_arvalid  = ~rst & gnt_vld & (gnt_idx ? axi_mst1_arvalid : axi_mst0_arvalid);
  assign axi_slv_arid     = rst ? '0 : (gnt_idx ? axi_mst1_arid    : axi_mst0_arid);
  assign axi_slv_araddr   = rst ? '0 : (gnt_idx ? axi_mst1_araddr  : axi_mst0_araddr);
  assign axi_slv_arlen    = rst ? '0 : (gnt_idx ? axi_mst1_arlen   : axi_mst0_arlen);
  assign axi_slv_arsize   = rst ? '0 : (gnt_idx ? axi_mst1_arsize  : axi_mst0_arsize);
  assign axi_slv_arburst  = rst ? '0 : (gnt_idx ? axi_mst1_arburst : axi_mst0_arburst);
  assign axi_mst0_arready = ~rst & gnt_vld & ~gnt_idx & axi_slv_arready;
  assign axi_mst1_arready = ~rst & gnt_vld &  gnt_idx & axi_slv_arready;

  // R path, steered by the oldest outstanding grant
  assign axi_mst0_rvalid = ~rst & ~empty & ~head & axi_slv_rvalid;
  assign axi_mst1_rvalid = ~rst & ~empty &  head & axi_slv_rvalid;
  assign axi_slv_rready  = ~rst & ~empty & (head ? axi_mst1_rready : axi_mst0_rready);
  assign axi_mst0_rid    = rst ? '0 : axi_slv_rid;
  assign axi_mst0_rdata  = rst ? '0 : axi_slv_rdata;
  assign axi_mst0_rresp  = rst ? '0 : axi_slv_rresp;
  assign axi_mst0_rlast  = ~rst & axi_slv_rlast;
  assign axi_mst1_rid    = rst ? '0 : axi_slv_rid;
  assign axi_mst1_rdata  = rst ? '0 : axi_slv_rdata;
  assign axi_mst1_rresp  = rst ? '0 : axi_slv_rresp;
  assign axi_mst1_rlast  = ~rst & axi_slv_rlast;

  assign ar_hs = axi_slv_arvalid & axi_slv_arready;
  assign push  = ar_hs;
  assign pop   = axi_slv_rvalid & axi_slv_rready & axi_slv_rlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r   <= 1'b0;
      lock_r     <= 1'b0;
      lock_idx_r <= 1'b0;
      fifo_r     <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      cnt_r      <= '0;
    end else begin
      if (ar_hs) begin
        lock_r           <= 1'b0;
        rr_ptr_r         <= ~gnt_idx;
        fifo_r[wr_ptr_r] <= gnt_idx;
        wr_ptr_r         <= wr_ptr_r + 1'b1;
      end else if (axi_slv_arvalid) begin
        // slave stalled: pin the grant so the payload cannot switch masters
        lock_r     <= 1'b1;
        lock_idx_r <= gnt_idx;
      end
      if (pop)
        rd_ptr_r <= rd_ptr_r + 1'b1;
      if (push && !pop)
        cnt_r <= cnt_r + 1'b1;
      else if (pop && !push)
        cnt_r <= cnt_r - 1'b1;
    end
  end

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Randomized bench for easyaxi_rd_arb: queue-based reference model predicts grants
// and R routing; a negedge monitor pops the expectations as handshakes appear.
module tb_easyaxi_rd_arb;
  localparam int DEPTH = 8, IDW = 4, AW = 32, LW = 8, SW = 3, BW = 2, DW = 32, RW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable;
  logic [1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [IDW-1:0] m_arid [2];
  logic [AW-1:0]  m_araddr [2];
  logic [LW-1:0]  m_arlen [2];
  logic [SW-1:0]  m_arsize [2];
  logic [BW-1:0]  m_arburst [2];
  logic [IDW-1:0] m_rid [2];
  logic [DW-1:0]  m_rdata [2];
  logic [RW-1:0]  m_rresp [2];
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [IDW-1:0] s_arid, s_rid;
  logic [AW-1:0]  s_araddr;
  logic [LW-1:0]  s_arlen;
  logic [SW-1:0]  s_arsize;
  logic [BW-1:0]  s_arburst;
  logic [DW-1:0]  s_rdata;
  logic [RW-1:0]  s_rresp;

  easyaxi_rd_arb #(.OST_DEPTH(DEPTH), .AXI_ID_W(IDW), .AXI_ADDR_W(AW), .AXI_LEN_W(LW),
    .AXI_SIZE_W(SW), .AXI_BURST_W(BW), .AXI_DATA_W(DW), .AXI_RESP_W(RW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .axi_mst0_arvalid(m_arvalid[0]), .axi_mst0_arready(m_arready[0]),
    .axi_mst0_arid(m_arid[0]), .axi_mst0_araddr(m_araddr[0]), .axi_mst0_arlen(m_arlen[0]),
    .axi_mst0_arsize(m_arsize[0]), .axi_mst0_arburst(m_arburst[0]),
    .axi_mst0_rvalid(m_rvalid[0]), .axi_mst0_rready(m_rready[0]),
    .axi_mst0_rid(m_rid[0]), .axi_mst0_rdata(m_rdata[0]), .axi_mst0_rresp(m_rresp[0]),
    .axi_mst0_rlast(m_rlast[0]),
    .axi_mst1_arvalid(m_arvalid[1]), .axi_mst1_arready(m_arready[1]),
    .axi_mst1_arid(m_arid[1]), .axi_mst1_araddr(m_araddr[1]), .axi_mst1_arlen(m_arlen[1]),
    .axi_mst1_arsize(m_arsize[1]), .axi_mst1_arburst(m_arburst[1]),
    .axi_mst1_rvalid(m_rvalid[1]), .axi_mst1_rready(m_rready[1]),
    .axi_mst1_rid(m_rid[1]), .axi_mst1_rdata(m_rdata[1]), .axi_mst1_rresp(m_rresp[1]),
    .axi_mst1_rlast(m_rlast[1]),
    .axi_slv_arvalid(s_arvalid), .axi_slv_arready(s_arready),
    .axi_slv_arid(s_arid), .axi_slv_araddr(s_araddr), .axi_slv_arlen(s_arlen),
    .axi_slv_arsize(s_arsize), .axi_slv_arburst(s_arburst),
    .axi_slv_rvalid(s_rvalid), .axi_slv_rready(s_rready),
    .axi_slv_rid(s_rid), .axi_slv_rdata(s_rdata), .axi_slv_rresp(s_rresp),
    .axi_slv_rlast(s_rlast)
  );

  typedef struct { logic [IDW-1:0] id; logic [AW-1:0] addr; logic [LW-1:0] len;
                   logic [SW-1:0] size; logic [BW-1:0] burst; } ar_t;
  typedef struct { bit mst; logic [IDW-1:0] id; logic [DW-1:0] data;
                   logic [RW-1:0] resp; logic last; } r_t;
  typedef struct { logic [IDW-1:0] id; int len; } sb_t;

  int n_chk = 0, n_fail = 0;
  ar_t exp_ar_q[$];
  r_t  exp_r_q[$];
  bit  own_q[$];            // reference: owners of outstanding bursts, oldest first
  bit  mdl_rr = 0, mdl_lock = 0, mdl_lock_idx = 0;
  sb_t slv_q[$];            // TB slave: accepted bursts awaiting R beats
  int  beat = 0;
  logic [1:0] m_hs = '0;
  logic s_rhs = 1'b0;
  int p_ar, p_sar, p_rv, p_rr, p_en;
  logic rst_req;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    logic was_rst;
    was_rst = rst;
    rst = rst_req;
    enable = ($urandom_range(99) < p_en);
    for (int i = 0; i < 2; i++) begin
      if (!(m_arvalid[i] && !m_hs[i])) begin
        m_arvalid[i] = ($urandom_range(99) < p_ar);
        m_arid[i]    = IDW'($urandom);
        m_araddr[i]  = $urandom;
        m_arlen[i]   = LW'($urandom_range(3));
        m_arsize[i]  = SW'($urandom);
        m_arburst[i] = BW'($urandom);
      end
      m_rready[i] = ($urandom_range(99) < p_rr);
    end
    s_arready = ($urandom_range(99) < p_sar);
    if (!(s_rvalid && !s_rhs && !was_rst)) begin
      s_rdata = $urandom;
      s_rresp = RW'($urandom);
      if (slv_q.size() > 0 && $urandom_range(99) < p_rv) begin
        s_rvalid = 1'b1;
        s_rid    = slv_q[0].id;
        s_rlast  = (beat == slv_q[0].len);
      end else begin
        s_rvalid = 1'b0;
        s_rid    = IDW'($urandom);
        s_rlast  = 1'($urandom);
      end
    end
  endtask

  // Reference model: evaluates this cycle's expected control outputs from the
  // arbitration rules, then records the handshakes it predicts.
  task automatic model_step();
    bit gv, g, have, h, e_sav, e_srr;
    logic [1:0] e_ard, e_rv;
    if (rst) begin
      check("rst_ctrl", {m_arready, m_rvalid, s_arvalid, s_rready}, '0);
      check("rst_ar_payload", |{s_arid, s_araddr, s_arlen, s_arsize, s_arburst}, 0);
      check("rst_r_payload", |{m_rid[0], m_rdata[0], m_rresp[0], m_rid[1], m_rdata[1],
                               m_rresp[1], m_rlast}, 0);
      mdl_rr = 0; mdl_lock = 0; mdl_lock_idx = 0;
      own_q.delete(); exp_ar_q.delete(); exp_r_q.delete();
      return;
    end
    gv = 0; g = 0;
    if (mdl_lock) begin
      gv = 1; g = mdl_lock_idx;
    end else if (enable && own_q.size() < DEPTH) begin
      if (m_arvalid == 2'b11) begin gv = 1; g = mdl_rr; end
      else if (m_arvalid != 2'b00) begin gv = 1; g = m_arvalid[1]; end
    end
    e_sav = gv && m_arvalid[g];
    e_ard = {gv && g && s_arready, gv && !g && s_arready};
    have  = own_q.size() > 0;
    h     = have ? own_q[0] : 1'b0;
    e_rv  = {have && h && s_rvalid, have && !h && s_rvalid};
    e_srr = have && m_rready[h];
    check("slv_arvalid", s_arvalid, e_sav);
    check("mst_arready", m_arready, e_ard);
    check("mst_rvalid", m_rvalid, e_rv);
    check("slv_rready", s_rready, e_srr);
    check("r_fanout", {m_rdata[0], m_rdata[1]}, {s_rdata, s_rdata});
    if (e_sav)
      check("ar_mux", {s_arid, s_araddr}, {m_arid[g], m_araddr[g]});
    if (have && s_rvalid && m_rready[h]) begin
      exp_r_q.push_back('{h, s_rid, s_rdata, s_rresp, s_rlast});
      if (s_rlast) void'(own_q.pop_front());
    end
    if (e_sav && s_arready) begin
      exp_ar_q.push_back('{m_arid[g], m_araddr[g], m_arlen[g], m_arsize[g], m_arburst[g]});
      mdl_lock = 0; mdl_rr = ~g; own_q.push_back(g);
    end else if (e_sav) begin
      mdl_lock = 1; mdl_lock_idx = g;
    end
  endtask

  // Monitor: pops expectations whenever the DUT completes a handshake; also
  // plays the slave's bookkeeping for the R beats it returns.
  always @(negedge clk) begin
    m_hs  = m_arvalid & m_arready;
    s_rhs = s_rvalid & s_rready;
    if (rst) begin
      slv_q.delete();
      beat = 0;
    end else begin
      if (s_arvalid && s_arready) begin
        ar_t e;
        slv_q.push_back('{s_arid, int'(s_arlen)});
        check("ar_expected", exp_ar_q.size() != 0, 1);
        if (exp_ar_q.size() != 0) begin
          e = exp_ar_q.pop_front();
          check("ar_payload", {s_arid, s_araddr, s_arlen, s_arsize, s_arburst},
                {e.id, e.addr, e.len, e.size, e.burst});
        end
      end
      if (s_rhs) begin
        if (s_rlast) begin
          if (slv_q.size() != 0) void'(slv_q.pop_front());
          beat = 0;
        end else beat++;
      end
      for (int i = 0; i < 2; i++) begin
        if (m_rvalid[i] && m_rready[i]) begin
          r_t e;
          check("r_expected", exp_r_q.size() != 0, 1);
          if (exp_r_q.size() != 0) begin
            e = exp_r_q.pop_front();
            check("r_owner", i, e.mst);
            check("r_beat", {m_rid[i], m_rdata[i], m_rresp[i], m_rlast[i]},
                  {e.id, e.data, e.resp, e.last});
          end
        end
      end
    end
  end

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1 drive();
      #2 model_step();
    end
  endtask

  initial begin
    rst = 1'b1; rst_req = 1'b1; enable = 1'b0;
    m_arvalid = '0; m_rready = '0; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    s_rid = '0; s_rdata = '0; s_rresp = '0;
    for (int i = 0; i < 2; i++) begin
      m_arid[i] = '0; m_araddr[i] = '0; m_arlen[i] = '0; m_arsize[i] = '0; m_arburst[i] = '0;
    end
    p_ar = 50; p_sar = 70; p_rv = 70; p_rr = 70; p_en = 100;
    run(3);
    rst_req = 1'b0;
    run(300);
    // starve R so the grant FIFO fills, then let it drain with contention
    p_ar = 95; p_sar = 80; p_rv = 0;
    run(80);
    p_rv = 40; p_rr = 30;
    run(300);
    // reset in the middle of a burst
    p_rv = 90; p_rr = 90;
    for (int c = 0; c < 300; c++) begin
      run(1);
      if (beat >= 2) break;
    end
    rst_req = 1'b1;
    run(1);
    rst_req = 1'b0;
    p_ar = 60; p_sar = 50; p_rv = 60; p_rr = 60; p_en = 70;
    run(400);
    // drain: no new requests, everything ready
    p_ar = 0; p_sar = 100; p_rv = 100; p_rr = 100; p_en = 100;
    for (int c = 0; c < 500; c++) begin
      run(1);
      if (own_q.size() == 0 && slv_q.size() == 0 && m_arvalid == 2'b00) break;
    end
    run(2);
    check("drain_outstanding", own_q.size(), 0);
    check("drain_ar_left", exp_ar_q.size(), 0);
    check("drain_r_left", exp_r_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
